wsum_encoder: RTL and testbench

WSUM_ENCODER -- requirements
Module: wsum_encoder

---
 rtl/wsum_pkg.sv | 23 ++
 rtl/wsum_serializer.sv | 84 ++++++++
 rtl/wsum_encoder.sv | 111 +++++++++++
 tb/tb_wsum_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wsum_pkg.sv
// Shared constants, serializer state encoding and width helper for the windowed-sum encoder.
package wsum_pkg;

  localparam int unsigned DEF_DIN_W = 8;
  localparam int unsigned DEF_BLK_W = 3;
  localparam int unsigned DEF_NBLK  = 2;
  localparam int unsigned DEF_BLK_H = 3;
  localparam int unsigned DEF_SUM_W = 16;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_EMIT = 1'b1
  } ser_state_t;

  // Bits needed to hold values 0..v-1, never less than 1 so counters stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/wsum_serializer.sv
// Shadow buffer and byte serializer: holds one block-row record and streams it MSB first.
module wsum_serializer
  import wsum_pkg::*;
#(
  parameter int unsigned REC_W = 32
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [REC_W-1:0] load_data,
  input  logic             dout_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             accept_c
);

  localparam int unsigned NBYTES = REC_W / 8;
  localparam int unsigned IDX_W  = clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_t       state, state_nxt;
  logic [REC_W-1:0] shadow, shadow_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       dout_nxt;
  logic             valid_nxt, last_nxt;
  logic             hs, final_hs;

  assign hs       = (state == SER_EMIT) && dout_ready;
  assign final_hs = hs && (idx == LAST_IDX);
  // A new record fits if idle or if the final byte leaves this very cycle.
  assign accept_c = (state == SER_IDLE) || final_hs;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = idx;
    dout_nxt   = dout;
    valid_nxt  = dout_valid;
    last_nxt   = dout_last;
    if (flush) begin
      state_nxt = SER_IDLE;
      idx_nxt   = '0;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else if (load && accept_c) begin
      state_nxt  = SER_EMIT;
      dout_nxt   = load_data[REC_W-1 -: 8];
      shadow_nxt = load_data << 8;
      idx_nxt    = '0;
      valid_nxt  = 1'b1;
      last_nxt   = (NBYTES == 1);
    end else if (final_hs) begin
      state_nxt = SER_IDLE;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else if (hs) begin
      dout_nxt   = shadow[REC_W-1 -: 8];
      shadow_nxt = shadow << 8;
      idx_nxt    = idx + IDX_W'(1);
      last_nxt   = (idx_nxt == LAST_IDX);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= SER_IDLE;
      shadow     <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow     <= shadow_nxt;
      idx        <= idx_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
      dout_last  <= last_nxt;
    end
  end

endmodule

// File: rtl/wsum_encoder.sv
// Per-block pixel sums over BLK_H lines, handed to a byte serializer at each block-row end.
module wsum_encoder
  import wsum_pkg::*;
#(
  parameter int unsigned DIN_W = DEF_DIN_W,
  parameter int unsigned BLK_W = DEF_BLK_W,
  parameter int unsigned NBLK  = DEF_NBLK,
  parameter int unsigned BLK_H = DEF_BLK_H,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic             pix_valid,
  input  logic [DIN_W-1:0] din,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             overflow
);

  localparam int unsigned NCOL   = NBLK * BLK_W;
  localparam int unsigned COL_W  = clog2(NCOL + 1);
  localparam int unsigned SUB_W  = clog2(BLK_W);
  localparam int unsigned BIDX_W = clog2(NBLK);
  localparam int unsigned LINE_W = clog2(BLK_H);
  localparam int unsigned REC_W  = NBLK * SUM_W;
  localparam int unsigned ACC_W1 = SUM_W + 1;

  logic [COL_W-1:0]  col;
  logic [SUB_W-1:0]  sub;
  logic [BIDX_W-1:0] blk;
  logic [LINE_W-1:0] line;
  logic              in_line;
  logic [SUM_W-1:0]  acc     [NBLK];
  logic [SUM_W-1:0]  acc_add [NBLK];
  logic [ACC_W1-1:0] raw_sum;
  logic [SUM_W-1:0]  sat_sum;
  logic [REC_W-1:0]  rec;
  logic              accept_pix, complete, ser_accept_c;

  assign accept_pix = pix_valid && in_line && !line_start && !frame_start
                      && (col < COL_W'(NCOL));
  assign complete   = accept_pix && (col == COL_W'(NCOL - 1))
                      && (line == LINE_W'(BLK_H - 1));

  // Saturating add of the current pixel; rec packs block 0 into the top bits.
  always_comb begin
    raw_sum = {1'b0, acc[blk]} + ACC_W1'(din);
    sat_sum = raw_sum[SUM_W] ? '1 : raw_sum[SUM_W-1:0];
    rec     = '0;
    for (int unsigned b = 0; b < NBLK; b++) begin
      acc_add[b] = (accept_pix && (blk == BIDX_W'(b))) ? sat_sum : acc[b];
      rec[(NBLK-1-b)*SUM_W +: SUM_W] = acc_add[b];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst || frame_start) begin
      col      <= '0;
      sub      <= '0;
      blk      <= '0;
      line     <= '0;
      in_line  <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned b = 0; b < NBLK; b++) acc[b] <= '0;
    end else begin
      if (line_start) begin
        col     <= '0;
        sub     <= '0;
        blk     <= '0;
        in_line <= 1'b1;
        if (!in_line || (line == LINE_W'(BLK_H - 1))) line <= '0;
        else                                          line <= line + LINE_W'(1);
      end else if (accept_pix) begin
        col <= col + COL_W'(1);
        if (sub == SUB_W'(BLK_W - 1)) begin
          sub <= '0;
          if (blk != BIDX_W'(NBLK - 1)) blk <= blk + BIDX_W'(1);
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
      // Accumulators restart at every completion, whether or not the row is kept.
      if (complete) begin
        for (int unsigned b = 0; b < NBLK; b++) acc[b] <= '0;
        if (!ser_accept_c) overflow <= 1'b1;
      end else begin
        for (int unsigned b = 0; b < NBLK; b++) acc[b] <= acc_add[b];
      end
    end
  end

  wsum_serializer #(
    .REC_W (REC_W)
  ) u_ser (
    .pclk       (pclk),
    .rst        (rst),
    .flush      (frame_start),
    .load       (complete),
    .load_data  (rec),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .accept_c   (ser_accept_c)
  );

endmodule

// File: tb/tb_wsum_encoder.sv
// Table-driven and directed checks of wsum_encoder with a byte scoreboard.
`timescale 1ns/1ps
module tb_wsum_encoder;

  logic       pclk = 1'b0;
  logic       rst = 1'b1, frame_start = 1'b0, line_start = 1'b0, pix_valid = 1'b0;
  logic       dout_ready = 1'b1, sel8 = 1'b0, rnd_ready = 1'b0;
  logic [7:0] din = 8'd0;
  logic       pv0, pv1;
  logic [7:0] dout0, dout1;
  logic       v0, v1, last0, last1, ovf0, ovf1;

  int unsigned n_chk = 0, n_fail = 0;
  logic [8:0]  q0[$], q1[$];
  logic [8:0]  e0, e1;
  logic        hold0 = 1'b0, hold_l = 1'b0;
  logic [7:0]  hold_d = 8'd0;
  int unsigned msum[2];

  assign pv0 = pix_valid && !sel8;
  assign pv1 = pix_valid && sel8;

  always #5 pclk = ~pclk;

  wsum_encoder dut (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .pix_valid(pv0), .din(din), .dout(dout0), .dout_valid(v0),
    .dout_ready(dout_ready), .dout_last(last0), .overflow(ovf0));

  wsum_encoder #(.SUM_W(8)) dut8 (
    .pclk(pclk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .pix_valid(pv1), .din(din), .dout(dout1), .dout_valid(v1),
    .dout_ready(dout_ready), .dout_last(last1), .overflow(ovf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: pop on each handshake; also check hold-stable during stalls.
  always @(negedge pclk) begin
    if (!rst) begin
      if (hold0 && v0) begin
        chk("hold_dout", 32'(dout0), 32'(hold_d));
        chk("hold_last", 32'(last0), 32'(hold_l));
      end
      if (v0 && dout_ready) begin
        chk("byte_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("dout", 32'({last0, dout0}), 32'(e0));
        end
      end
      if (v1 && dout_ready) begin
        chk("byte8_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("dout8", 32'({last1, dout1}), 32'(e1));
        end
      end
    end
    hold0  = v0 && !dout_ready;
    hold_d = dout0;
    hold_l = last0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
    if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_rec(input logic [31:0] r);
    for (int k = 0; k < 4; k++) q0.push_back({(k == 3), r[31-8*k -: 8]});
  endtask

  task automatic pulse_frame(input bit noise);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (noise) begin
      pix_valid = 1'b1;
      din = 8'd200;
      repeat (3) tick();
      pix_valid = 1'b0;
    end
  endtask

  // mode 0: din = pix+line+1, mode 1: 255, mode 2: random into msum.
  task automatic send_row(input int unsigned lb, input bit noise, input int mode,
                          input bit exp_load, input bit overlap);
    logic vs;
    msum[0] = 0;
    msum[1] = 0;
    for (int l = 0; l < 3; l++) begin
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      for (int p = 0; p < 6; p++) begin
        pix_valid = 1'b1;
        case (mode)
          0:       din = 8'(p + int'(lb) + l + 1);
          1:       din = 8'hFF;
          default: din = 8'($urandom_range(0, 255));
        endcase
        msum[p/3] += 32'(din);
        if (overlap && l == 2 && p == 2) dout_ready = 1'b1;
        vs = sel8 ? v1 : v0;
        if (exp_load && !overlap && l == 2 && p == 5) chk("valid_before_load", 32'(vs), 32'd0);
        tick();
        vs = sel8 ? v1 : v0;
        if (exp_load && l == 2 && p == 5) chk("load_latency", 32'(vs), 32'd1);
      end
      if (noise) begin
        din = 8'd200;
        repeat (2) tick();
      end
      pix_valid = 1'b0;
      tick();
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
    chk("valid_low_after_last", 32'(v0 | v1), 32'd0);
  endtask

  typedef struct {
    int unsigned lb;
    bit          frame;
    bit          noise;
    logic [31:0] rec;
  } vec_t;
  vec_t tab[4];

  initial begin
    tab[0] = '{0, 1'b1, 1'b1, 32'h001B_0036};
    tab[1] = '{3, 1'b0, 1'b0, 32'h0036_0051};
    tab[2] = '{6, 1'b0, 1'b1, 32'h0051_006C};
    tab[3] = '{0, 1'b1, 1'b1, 32'h001B_0036};

    repeat (3) tick();
    chk("rst_dout", 32'(dout0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_last", 32'(last0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      if (tab[i].frame) pulse_frame(tab[i].noise);
      push_rec(tab[i].rec);
      send_row(tab[i].lb, tab[i].noise, 0, 1'b1, 1'b0);
      wait_drain(100);
      chk("ovf_clear", 32'(ovf0), 32'd0);
    end

    // Stall across two completed rows: second row dropped, overflow sticky.
    dout_ready = 1'b0;
    pulse_frame(1'b0);
    push_rec(32'h001B_0036);
    send_row(0, 1'b0, 0, 1'b1, 1'b0);
    send_row(3, 1'b0, 0, 1'b0, 1'b0);
    chk("stall_ovf", 32'(ovf0), 32'd1);
    chk("stall_valid", 32'(v0), 32'd1);
    chk("stall_dout", 32'(dout0), 32'd0);
    dout_ready = 1'b1;
    wait_drain(100);
    repeat (10) tick();
    chk("ovf_sticky", 32'(ovf0), 32'd1);

    // Completion on the same edge as the final-byte handshake is kept.
    dout_ready = 1'b0;
    pulse_frame(1'b0);
    chk("frame_clears_ovf", 32'(ovf0), 32'd0);
    push_rec(32'h001B_0036);
    send_row(0, 1'b0, 0, 1'b1, 1'b0);
    push_rec(32'h0036_0051);
    send_row(3, 1'b0, 0, 1'b1, 1'b1);
    wait_drain(100);
    chk("overlap_ovf", 32'(ovf0), 32'd0);

    // frame_start after two bytes aborts the record.
    dout_ready = 1'b0;
    pulse_frame(1'b0);
    push_rec(32'h001B_0036);
    send_row(0, 1'b0, 0, 1'b1, 1'b0);
    dout_ready = 1'b1;
    tick();
    tick();
    dout_ready = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("abort_valid", 32'(v0), 32'd0);
    chk("abort_bytes_left", 32'(q0.size()), 32'd2);
    q0.delete();
    dout_ready = 1'b1;
    push_rec(32'h001B_0036);
    send_row(0, 1'b0, 0, 1'b1, 1'b0);
    wait_drain(100);

    // rst mid-record drops it.
    dout_ready = 1'b0;
    pulse_frame(1'b0);
    send_row(0, 1'b0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(v0), 32'd0);
    chk("rst_mid_dout", 32'(dout0), 32'd0);
    dout_ready = 1'b1;
    repeat (8) tick();

    // Random pixels with random backpressure against a running-sum model.
    pulse_frame(1'b0);
    rnd_ready = 1'b1;
    send_row(0, 1'b0, 2, 1'b1, 1'b0);
    push_rec({16'(msum[0]), 16'(msum[1])});
    rnd_ready = 1'b0;
    dout_ready = 1'b1;
    wait_drain(200);

    // SUM_W=8 instance saturates at FF.
    sel8 = 1'b1;
    pulse_frame(1'b0);
    q1.push_back({1'b0, 8'hFF});
    q1.push_back({1'b1, 8'hFF});
    send_row(0, 1'b0, 1, 1'b1, 1'b0);
    wait_drain(100);
    chk("sat_ovf", 32'(ovf1), 32'd0);
    sel8 = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
